// File: rtl/alu_multicycle.sv
// alu_multicycle: registered accumulator-datapath ALU, AC (op) Bus -> result.
// The operands and opcode are latched on a start/done handshake. Single-cycle
// ops finish one cycle after they are accepted. MUL is a reg_width-cycle
// shift-add sequence. The block also produces zero/neg/carry flags for branch logic.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-low reset
//   start          request, sampled only in IDLE/DONE
//   ALU_Operation  opcode (latched on accept)
//   AC, Bus        operands A and B (latched on accept)
//   result         registered result, holds until the next done
//   busy           operation in flight
//   done           one-cycle pulse when result/flags update
//   zero/neg/carry flags of the written result
module alu_multicycle #(
  parameter int unsigned reg_width = 12,
  parameter int unsigned MUL_EN    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [2:0]           ALU_Operation,
  input  logic [reg_width-1:0] AC,
  input  logic [reg_width-1:0] Bus,
  output logic [reg_width-1:0] result,
  output logic                 busy,
  output logic                 done,
  output logic                 zero,
  output logic                 neg,
  output logic                 carry
);

  localparam int unsigned W     = reg_width;
  localparam int unsigned CNT_W = $clog2(reg_width);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_MUL  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SHL = 3'b100;
  localparam logic [2:0] OP_SHR = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_XOR = 3'b111;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

  logic [1:0]       state_q,  state_d;
  logic [2:0]       op_q,     op_d;
  logic [2*W-1:0]   mcand_q,  mcand_d;   // operand A, zero-extended; shifted left during MUL
  logic [W-1:0]     mplier_q, mplier_d;  // operand B; shifted right during MUL
  logic [2*W-1:0]   acc_q,    acc_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [W-1:0]     result_q, result_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;
  logic             zero_q,   zero_d;
  logic             neg_q,    neg_d;
  logic             carry_q,  carry_d;

  logic [W-1:0]     opa;
  logic [W:0]       sum_w;
  logic [W:0]       diff_w;
  logic [W-1:0]     exec_res;
  logic             exec_carry;
  logic [2*W-1:0]   acc_step;
  logic             is_mul;
  logic             wr_en;
  logic [W-1:0]     wr_res;
  logic             wr_carry;

  assign opa    = mcand_q[W-1:0];
  assign is_mul = (ALU_Operation == OP_MUL) && (MUL_EN != 0);

  // Single-cycle datapath on the latched operands; opcode 110 here is the NOP case.
  always_comb begin
    sum_w      = {1'b0, opa} + {1'b0, mplier_q};
    diff_w     = {1'b0, opa} - {1'b0, mplier_q};
    exec_res   = opa;
    exec_carry = 1'b0;
    case (op_q)
      OP_ADD: begin exec_res = sum_w[W-1:0];  exec_carry = sum_w[W];  end
      OP_SUB: begin exec_res = diff_w[W-1:0]; exec_carry = diff_w[W]; end
      OP_AND: exec_res = opa & mplier_q;
      OP_OR:  exec_res = opa | mplier_q;
      OP_XOR: exec_res = opa ^ mplier_q;
      OP_SHL: begin exec_res = {opa[W-2:0], 1'b0}; exec_carry = opa[W-1]; end
      OP_SHR: begin exec_res = {1'b0, opa[W-1:1]}; exec_carry = opa[0];   end
      default: ;
    endcase
  end

  // One shift-add step: add the shifted multiplicand when the multiplier LSB is set.
  assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    zero_d   = zero_q;
    neg_d    = neg_q;
    carry_d  = carry_q;
    wr_en    = 1'b0;
    wr_res   = '0;
    wr_carry = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          op_d     = ALU_Operation;
          mcand_d  = {{W{1'b0}}, AC};
          mplier_d = Bus;
          acc_d    = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = is_mul ? ST_MUL : ST_EXEC;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_EXEC: begin
        wr_en    = 1'b1;
        wr_res   = exec_res;
        wr_carry = exec_carry;
        state_d  = ST_DONE;
      end
      ST_MUL: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        // The last step's sum is the full product; write it straight out.
        if (cnt_q == CNT_LAST) begin
          wr_en    = 1'b1;
          wr_res   = acc_step[W-1:0];
          wr_carry = |acc_step[2*W-1:W];
          state_d  = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (wr_en) begin
      result_d = wr_res;
      zero_d   = (wr_res == '0);
      neg_d    = wr_res[W-1];
      carry_d  = wr_carry;
      done_d   = 1'b1;
      busy_d   = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      carry_q  <= carry_d;
    end
  end

  assign result = result_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign zero   = zero_q;
  assign neg    = neg_q;
  assign carry  = carry_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle: three instances (12-bit, 12-bit without MUL, 16-bit)
// checked against a plain-arithmetic reference model.
module tb_alu_multicycle;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  op;
  logic [15:0] ac, bus;
  logic        start_a, start_n, start_w;

  logic [11:0] res_a, res_n;
  logic [15:0] res_w;
  logic busy_a, done_a, zero_a, neg_a, carry_a;
  logic busy_n, done_n, zero_n, neg_n, carry_n;
  logic busy_w, done_w, zero_w, neg_w, carry_w;

  int          sel;
  logic [15:0] o_res;
  logic        o_busy, o_done, o_zero, o_neg, o_carry;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011;
  localparam logic [2:0] SHL = 3'b100, SHR = 3'b101, MUL = 3'b110, XOR_ = 3'b111;

  typedef struct packed {
    logic [7:0]  lat;
    logic [7:0]  bcnt;
    logic [15:0] res;
    logic        zero;
    logic        neg;
    logic        carry;
    logic        done_after;
  } obs_t;

  typedef struct packed {
    logic [1:0]  which;
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        z;
    logic        n;
    logic        c;
    logic [7:0]  lat;
  } vec_t;

  always #5 clk = ~clk;

  alu_multicycle #(.reg_width(12), .MUL_EN(1)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .ALU_Operation(op),
    .AC(ac[11:0]), .Bus(bus[11:0]), .result(res_a), .busy(busy_a),
    .done(done_a), .zero(zero_a), .neg(neg_a), .carry(carry_a));

  alu_multicycle #(.reg_width(12), .MUL_EN(0)) dut_n (
    .clk(clk), .reset(reset), .start(start_n), .ALU_Operation(op),
    .AC(ac[11:0]), .Bus(bus[11:0]), .result(res_n), .busy(busy_n),
    .done(done_n), .zero(zero_n), .neg(neg_n), .carry(carry_n));

  alu_multicycle #(.reg_width(16), .MUL_EN(1)) dut_w (
    .clk(clk), .reset(reset), .start(start_w), .ALU_Operation(op),
    .AC(ac), .Bus(bus), .result(res_w), .busy(busy_w),
    .done(done_w), .zero(zero_w), .neg(neg_w), .carry(carry_w));

  // Observe the selected instance.
  always_comb begin
    case (sel)
      1: begin o_res = {4'h0, res_n}; o_busy = busy_n; o_done = done_n;
               o_zero = zero_n; o_neg = neg_n; o_carry = carry_n; end
      2: begin o_res = res_w; o_busy = busy_w; o_done = done_w;
               o_zero = zero_w; o_neg = neg_w; o_carry = carry_w; end
      default: begin o_res = {4'h0, res_a}; o_busy = busy_a; o_done = done_a;
               o_zero = zero_a; o_neg = neg_a; o_carry = carry_a; end
    endcase
  end

  // Reference model: the opcode table computed with wide integer arithmetic.
  function automatic obs_t expect_op(input int which, input logic [2:0] f_op,
                                     input logic [15:0] a_in, input logic [15:0] b_in);
    int     w;
    bit     me;
    longint mask, a, b, p, r;
    bit     c;
    obs_t   e;
    w    = (which == 2) ? 16 : 12;
    me   = (which != 1);
    mask = (longint'(1) << w) - 1;
    a    = longint'(a_in) & mask;
    b    = longint'(b_in) & mask;
    c    = 1'b0;
    r    = 0;
    case (f_op)
      ADD:  begin p = a + b; r = p & mask; c = ((p >> w) & 1) != 0; end
      SUB:  begin r = (a - b) & mask; c = (a < b); end
      AND_: r = a & b;
      OR_:  r = a | b;
      XOR_: r = a ^ b;
      SHL:  begin r = (a << 1) & mask; c = ((a >> (w - 1)) & 1) != 0; end
      SHR:  begin r = a >> 1; c = (a & 1) != 0; end
      default: begin
        if (me) begin p = a * b; r = p & mask; c = (p >> w) != 0; end
        else    begin r = a; c = 1'b0; end
      end
    endcase
    e.lat        = (f_op == MUL && me) ? 8'(w) : 8'd1;
    e.bcnt       = e.lat;
    e.res        = 16'(r);
    e.zero       = (r == 0);
    e.neg        = ((r >> (w - 1)) & 1) != 0;
    e.carry      = c;
    e.done_after = 1'b0;
    return e;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("lat=%0d busy_cycles=%0d result=%h zero=%b neg=%b carry=%b done_next=%b",
                     o.lat, o.bcnt, o.res, o.zero, o.neg, o.carry, o.done_after);
  endfunction

  // Issue one op on the chosen instance and record what it did.
  task automatic run_op(input int which, input logic [2:0] f_op, input logic [15:0] a,
                        input logic [15:0] b, output obs_t o);
    int cyc, bc;
    sel = which;
    @(negedge clk);
    op = f_op; ac = a; bus = b;
    start_a = (which == 0); start_n = (which == 1); start_w = (which == 2);
    @(posedge clk); #1;
    start_a = 1'b0; start_n = 1'b0; start_w = 1'b0;
    cyc = 0; bc = 0;
    while (o_done !== 1'b1 && cyc < 40) begin
      if (o_busy === 1'b1) bc++;
      @(posedge clk); #1;
      cyc++;
    end
    if (o_busy === 1'b1) bc++;
    o.lat = 8'(cyc); o.bcnt = 8'(bc); o.res = o_res;
    o.zero = o_zero; o.neg = o_neg; o.carry = o_carry;
    @(posedge clk); #1;
    o.done_after = o_done;
  endtask

  task automatic test_reset;
    reset = 1'b0; start_a = 0; start_n = 0; start_w = 0; op = '0; ac = '0; bus = '0; sel = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({res_a, busy_a, done_a, zero_a, neg_a, carry_a} !== 17'h0) begin
      errors++; $display("FAIL reset_a: got %h required 0", {res_a, busy_a, done_a, zero_a, neg_a, carry_a});
    end
    checks++;
    if ({res_n, busy_n, done_n, zero_n, neg_n, carry_n} !== 17'h0) begin
      errors++; $display("FAIL reset_n: got %h required 0", {res_n, busy_n, done_n, zero_n, neg_n, carry_n});
    end
    checks++;
    if ({res_w, busy_w, done_w, zero_w, neg_w, carry_w} !== 21'h0) begin
      errors++; $display("FAIL reset_w: got %h required 0", {res_w, busy_w, done_w, zero_w, neg_w, carry_w});
    end
    @(negedge clk); reset = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_directed;
    vec_t v[15];
    obs_t got, want;
    v[0]  = '{2'd0, XOR_, 16'h00CC, 16'h00C8, 16'h0004, 1'b0, 1'b0, 1'b0, 8'd1};
    v[1]  = '{2'd0, ADD,  16'h0FFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1, 8'd1};
    v[2]  = '{2'd0, SUB,  16'h0005, 16'h0007, 16'h0FFE, 1'b0, 1'b1, 1'b1, 8'd1};
    v[3]  = '{2'd0, SHR,  16'h0001, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 8'd1};
    v[4]  = '{2'd0, MUL,  16'h0010, 16'h000C, 16'h00C0, 1'b0, 1'b0, 1'b0, 8'd12};
    v[5]  = '{2'd0, MUL,  16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b0, 1'b1, 8'd12};
    v[6]  = '{2'd0, SHL,  16'h0801, 16'h0000, 16'h0002, 1'b0, 1'b0, 1'b1, 8'd1};
    v[7]  = '{2'd0, AND_, 16'h0FF0, 16'h00F0, 16'h00F0, 1'b0, 1'b0, 1'b0, 8'd1};
    v[8]  = '{2'd0, OR_,  16'h00F0, 16'h000F, 16'h00FF, 1'b0, 1'b0, 1'b0, 8'd1};
    v[9]  = '{2'd0, ADD,  16'h07FF, 16'h0001, 16'h0800, 1'b0, 1'b1, 1'b0, 8'd1};
    v[10] = '{2'd0, MUL,  16'h0FFF, 16'h0FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 8'd12};
    v[11] = '{2'd1, MUL,  16'h00A5, 16'h0123, 16'h00A5, 1'b0, 1'b0, 1'b0, 8'd1};
    v[12] = '{2'd2, ADD,  16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1, 8'd1};
    v[13] = '{2'd2, MUL,  16'h0010, 16'h000C, 16'h00C0, 1'b0, 1'b0, 1'b0, 8'd16};
    v[14] = '{2'd2, MUL,  16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b0, 1'b1, 8'd16};
    for (int i = 0; i < 15; i++) begin
      run_op(int'(v[i].which), v[i].op, v[i].a, v[i].b, got);
      want = '{v[i].lat, v[i].lat, v[i].res, v[i].z, v[i].n, v[i].c, 1'b0};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL directed[%0d]: got %s required %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  task automatic test_random;
    obs_t got, want;
    logic [2:0] r_op;
    logic [15:0] a, b;
    for (int which = 0; which < 3; which++) begin
      for (int i = 0; i < 25; i++) begin
        r_op = 3'($urandom_range(0, 7));
        a = 16'($urandom); b = 16'($urandom);
        want = expect_op(which, r_op, a, b);
        run_op(which, r_op, a, b, got);
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL random[%0d/%0d] op=%b a=%h b=%h: got %s required %s",
                   which, i, r_op, a, b, fmt(got), fmt(want));
        end
      end
    end
  endtask

  task automatic test_busy_ignore;
    obs_t want;
    logic [15:0] a, b, r;
    logic [2:0] f;
    int cyc, ndone;
    sel = 0;
    a = 16'($urandom_range(1, 4095)); b = 16'($urandom_range(1, 4095));
    want = expect_op(0, MUL, a, b);
    @(negedge clk); op = MUL; ac = a; bus = b; start_a = 1'b1;
    @(posedge clk); #1; start_a = 1'b0;
    cyc = 0; ndone = 0; r = '0; f = '0;
    for (int i = 1; i <= 40; i++) begin
      if (i >= 4 && i <= 6) begin
        @(negedge clk); op = ADD; ac = 16'($urandom); bus = 16'($urandom); start_a = 1'b1;
      end
      @(posedge clk); #1; start_a = 1'b0;
      if (o_done === 1'b1) begin
        ndone++;
        if (cyc == 0) begin cyc = i; r = o_res; f = {o_zero, o_neg, o_carry}; end
      end
      if (cyc != 0 && i >= cyc + 6) break;
    end
    checks++;
    if ({8'(cyc), r, f} !== {want.lat, want.res, want.zero, want.neg, want.carry}) begin
      errors++;
      $display("FAIL busy_ignore: got lat=%0d result=%h znc=%b required lat=%0d result=%h znc=%b",
               cyc, r, f, want.lat, want.res, {want.zero, want.neg, want.carry});
    end
    checks++;
    if (ndone != 1) begin
      errors++; $display("FAIL busy_ignore_done_count: got %0d required 1", ndone);
    end
  endtask

  task automatic test_back_to_back;
    obs_t e1, e2;
    logic [2:0] op1;
    logic [15:0] a1, b1, a2, b2, r1, r2;
    logic [2:0] f1, f2;
    int t1, t2, ndone;
    sel = 0;
    do op1 = 3'($urandom_range(0, 7)); while (op1 == MUL);
    a1 = 16'($urandom); b1 = 16'($urandom); a2 = 16'($urandom); b2 = 16'($urandom);
    e1 = expect_op(0, op1, a1, b1);
    e2 = expect_op(0, MUL, a2, b2);
    @(negedge clk); op = op1; ac = a1; bus = b1; start_a = 1'b1;
    @(posedge clk); #1;
    t1 = 0; t2 = 0; ndone = 0; r1 = '0; r2 = '0; f1 = '0; f2 = '0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (o_done === 1'b1) begin
        ndone++;
        if (t1 == 0) begin
          t1 = i; r1 = o_res; f1 = {o_zero, o_neg, o_carry};
          op = MUL; ac = a2; bus = b2;  // start stays high through DONE
        end else if (t2 == 0) begin
          t2 = i; r2 = o_res; f2 = {o_zero, o_neg, o_carry};
        end
      end
      if (t1 != 0 && i == t1 + 1) start_a = 1'b0;
    end
    start_a = 1'b0;
    checks++;
    if ({8'(t1), r1, f1} !== {8'd1, e1.res, e1.zero, e1.neg, e1.carry}) begin
      errors++;
      $display("FAIL b2b_first: got t=%0d result=%h znc=%b required t=1 result=%h znc=%b",
               t1, r1, f1, e1.res, {e1.zero, e1.neg, e1.carry});
    end
    checks++;
    if ({8'(t2), r2, f2} !== {8'd14, e2.res, e2.zero, e2.neg, e2.carry}) begin
      errors++;
      $display("FAIL b2b_second: got t=%0d result=%h znc=%b required t=14 result=%h znc=%b",
               t2, r2, f2, e2.res, {e2.zero, e2.neg, e2.carry});
    end
    checks++;
    if (ndone != 2) begin
      errors++; $display("FAIL b2b_done_count: got %0d required 2", ndone);
    end
  endtask

  task automatic test_reset_mid_mul;
    obs_t got, want;
    int ndone, nbusy;
    want = expect_op(0, OR_, 16'h00F0, 16'h000F);
    run_op(0, OR_, 16'h00F0, 16'h000F, got);
    checks++;
    if (got !== want) begin
      errors++; $display("FAIL pre_reset_or: got %s required %s", fmt(got), fmt(want));
    end
    @(negedge clk); op = MUL; ac = 16'h0123; bus = 16'h0456; start_a = 1'b1;
    @(posedge clk); #1; start_a = 1'b0;
    repeat (4) @(posedge clk);
    #3; reset = 1'b0;
    #1;
    checks++;
    if ({o_res, o_busy, o_done, o_zero, o_neg, o_carry} !== 21'h0) begin
      errors++;
      $display("FAIL reset_mid_mul: got result=%h busy=%b done=%b z=%b n=%b c=%b required all 0",
               o_res, o_busy, o_done, o_zero, o_neg, o_carry);
    end
    ndone = 0; nbusy = 0;
    repeat (2) begin @(posedge clk); #1; if (o_done !== 1'b0) ndone++; end
    @(negedge clk); reset = 1'b1;
    repeat (16) begin
      @(posedge clk); #1;
      if (o_done !== 1'b0) ndone++;
      if (o_busy !== 1'b0) nbusy++;
    end
    checks++;
    if (ndone != 0 || nbusy != 0) begin
      errors++; $display("FAIL reset_no_done: got done_cycles=%0d busy_cycles=%0d required 0/0", ndone, nbusy);
    end
    want = expect_op(0, XOR_, 16'h0A5A, 16'h0FF0);
    run_op(0, XOR_, 16'h0A5A, 16'h0FF0, got);
    checks++;
    if (got !== want) begin
      errors++; $display("FAIL post_reset_xor: got %s required %s", fmt(got), fmt(want));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_mul();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
